mul_array_sched: RTL and testbench

- Sequences the 64-lane 16x16 multiplier array for one convolution layer pass.
- Latches the kernel size and builds the per-lane multiplier enable mask (K*K lanes).
- Accepts one input-window/kernel operand set per handshake from the operand buffers and drives the lane enables that cycle.
- Tracks the multiplier pipeline latency so the downstream adder tree sees an aligned result-valid strobe. Collects lane overflow and reports pass completion.

---
 rtl/mul_array_sched.sv | 96 +++++++++
 tb/tb_mul_array_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mul_array_sched.sv
// mul_array_sched: sequences the multiplier array for one layer pass (mask, issue, latency, overflow).
// Define MUL_SCHED_OVF_ABORT_EN to stop issuing and drain once an overflow is sampled.
module mul_array_sched #(
  parameter int LANES   = 64,
  parameter int MUL_LAT = 1,
  parameter int WIN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ksize,
  input  logic [WIN_W-1:0] num_win,
  input  logic             win_valid,
  output logic             win_ready,
  output logic [LANES-1:0] mul_en,
  input  logic             ovf_in,
  output logic             res_valid,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             ovf_flag
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  localparam logic [MUL_LAT-1:0] TOP = MUL_LAT'(1) << (MUL_LAT - 1);
  logic [2:0]       r_state;
  logic [3:0]       r_k;
  logic [WIN_W-1:0] r_num, r_cnt;
  logic [LANES-1:0] r_mask, w_mask;
  logic [MUL_LAT-1:0] r_sr;
  logic             r_cfg_err, r_ovf;
  logic             w_issue, w_ovf, w_last, w_pend, w_kok;
  logic [6:0]       w_kk;
  assign w_kok     = ksize != 4'd0 && ksize <= 4'd8;
  assign w_kk      = 7'(r_k) * 7'(r_k);
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < LANES; i++) w_mask[i] = i < int'(w_kk);
  end
  assign win_ready = r_state == S_RUN;
  assign w_issue   = win_ready && win_valid;
  assign mul_en    = w_issue ? r_mask : '0;
  assign res_valid = r_sr[MUL_LAT-1];
  // Anything still in flight behind the output stage keeps the pass in DRAIN.
  assign w_pend    = |(r_sr & ~TOP);
  assign w_last    = r_cnt == r_num - WIN_W'(1);
  assign w_ovf     = res_valid && ovf_in;
  assign busy      = r_state != S_IDLE;
  assign done      = r_state == S_FIN;
  assign cfg_err   = r_cfg_err;
  assign ovf_flag  = r_ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_num     <= '0;
      r_cnt     <= '0;
      r_mask    <= '0;
      r_sr      <= '0;
      r_cfg_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      r_sr      <= MUL_LAT'({r_sr, w_issue});
      if (w_ovf) r_ovf <= 1'b1;
      case (r_state)
        S_IDLE: if (start) begin
          if (w_kok) begin
            r_k     <= ksize;
            r_num   <= num_win;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= S_LOAD;
          end else r_cfg_err <= 1'b1;
        end
        S_LOAD: begin
          r_mask  <= w_mask;
          r_state <= r_num != '0 ? S_RUN : S_FIN;
        end
        S_RUN: begin
          if (w_issue) r_cnt <= r_cnt + WIN_W'(1);
          if (w_issue && w_last) r_state <= S_DRAIN;
`ifdef MUL_SCHED_OVF_ABORT_EN
          if (w_ovf) r_state <= S_DRAIN;
`endif
        end
        S_DRAIN: if (!w_pend) r_state <= S_FIN;
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_array_sched.sv
// tb_mul_array_sched: directed passes; issues push expected result cycles, a monitor checks res_valid.
module tb_mul_array_sched;
  localparam int ML = 1;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, win_valid = 1'b0, ovf_in = 1'b0;
  logic [3:0]  ksize = '0;
  logic [15:0] num_win = '0;
  logic        win_ready, res_valid, busy, done, cfg_err, ovf_flag;
  logic [63:0] mul_en;
  int          cyc = 0, total = 0, bad = 0, mon_e;
  int          exp_q[$];
  logic        prev_ovf = 1'b0;

  mul_array_sched #(.LANES(64), .MUL_LAT(ML), .WIN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .ksize(ksize), .num_win(num_win),
    .win_valid(win_valid), .win_ready(win_ready), .mul_en(mul_en), .ovf_in(ovf_in),
    .res_valid(res_valid), .busy(busy), .done(done), .cfg_err(cfg_err), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (res_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("res_valid_unexpected", 64'(res_valid), 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("res_valid_cycle", 64'(cyc), 64'(mon_e));
      end
    end

  // t counts cycles from the start cycle; n_iss/done_off/ovf_hit are hand-derived per pass.
  task automatic run_pass(input int k, input int nw, input int n_iss, input int done_off,
                          input int ovf_cyc, input logic [15:0] vpat, input logic ovf_hit);
    int iss;
    logic [63:0] m;
    logic issue;
    iss = 0;
    m = (k * k >= 64) ? '1 : (64'd1 << (k * k)) - 64'd1;
    for (int t = 0; t <= done_off + 1; t++) begin
      tick();
      start     = (t == 0);
      ksize     = 4'(k);
      num_win   = 16'(nw);
      win_valid = t >= 2 && ((t - 2 < 16) ? vpat[t - 2] : 1'b1);
      ovf_in    = (t == ovf_cyc);
      #1;
      issue = t >= 2 && iss < n_iss && win_valid;
      chk("win_ready", 64'(win_ready), 64'(t >= 2 && iss < n_iss));
      chk("mul_en", mul_en, issue ? m : 64'd0);
      chk("busy", 64'(busy), 64'(t >= 1 && t <= done_off));
      chk("done", 64'(done), 64'(t == done_off));
      chk("ovf_flag", 64'(ovf_flag), 64'(t == 0 ? prev_ovf : (ovf_hit && t > ovf_cyc)));
      if (issue) begin
        exp_q.push_back(cyc + ML);
        iss++;
      end
    end
    start = 1'b0; win_valid = 1'b0; ovf_in = 1'b0;
    prev_ovf = ovf_hit;
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [3:0] badk [2];
    badk[0] = 4'd0;
    badk[1] = 4'd9;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_ovf_flag", 64'(ovf_flag), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_win_ready", 64'(win_ready), 64'd0);
    rst = 1'b0;
    run_pass(3, 4, 4, 7, -1, 16'hFFFF, 1'b0);
    run_pass(8, 3, 3, 7, -1, 16'b1101, 1'b0);
    run_pass(5, 0, 0, 2, -1, 16'hFFFF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      start = 1'b1; ksize = badk[i]; num_win = 16'd3; win_valid = 1'b1;
      #1 chk("cfg_err_pre", 64'(cfg_err), 64'd0);
      tick();
      start = 1'b0;
      #1;
      chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
      chk("cfg_busy", 64'(busy), 64'd0);
      chk("cfg_mul_en", mul_en, 64'd0);
      tick();
      #1;
      chk("cfg_err_clear", 64'(cfg_err), 64'd0);
      chk("cfg_busy2", 64'(busy), 64'd0);
      win_valid = 1'b0;
    end
`ifdef MUL_SCHED_OVF_ABORT_EN
    run_pass(2, 6, 3, 6, 4, 16'hFFFF, 1'b1);
`else
    run_pass(2, 6, 6, 9, 4, 16'hFFFF, 1'b1);
`endif
    tick();
    #1 chk("ovf_sticky_idle", 64'(ovf_flag), 64'd1);
    run_pass(1, 0, 0, 2, 1, 16'hFFFF, 1'b0);
    tick();
    start = 1'b1; ksize = 4'd1; num_win = 16'd5; win_valid = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      tick();
      start = 1'b0;
      #1;
      chk("rst_run_mul_en", mul_en, t >= 2 ? 64'd1 : 64'd0);
      if (t >= 2) exp_q.push_back(cyc + ML);
    end
    tick();
    rst = 1'b1; win_valid = 1'b0;
    tick();
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    chk("abort_win_ready", 64'(win_ready), 64'd0);
    chk("abort_mul_en", mul_en, 64'd0);
    chk("abort_ovf_flag", 64'(ovf_flag), 64'd0);
    rst = 1'b0;
    repeat (3) begin
      tick();
      #1;
      chk("abort_no_done", 64'(done), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
    end
    run_pass(1, 5, 5, 8, -1, 16'hFFFF, 1'b0);
    repeat (3) tick();
    chk("final_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
